// File: rtl/mxint_pkg.sv
// Shared types and helpers for the streaming MXINT block negate.
// Mode/policy encodings match the 2-bit i_mode / i_minval_policy fields.
package mxint_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'b00,
    NEG    = 2'b01,
    ABS    = 2'b10,
    NEGABS = 2'b11
  } mode_e;

  // Code 2'b11 is left unnamed and behaves as KEEP.
  typedef enum logic [1:0] {
    KEEP = 2'b00,
    ZERO = 2'b01,
    SAT  = 2'b10
  } policy_e;

  function automatic logic [63:0] minval_code(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] maxpos_code(input int w);
    return minval_code(w) - 64'd1;
  endfunction

  function automatic int beats_per_block(input int block_size, input int lanes);
    return block_size / lanes;
  endfunction

endpackage

// File: rtl/mxint_lane_negate.sv
// Combinational single-element pass/negate/abs/neg-abs with a policy for
// the most-negative code, which has no positive counterpart.
module mxint_lane_negate
  import mxint_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  mode_e        mode_i,
  input  policy_e      policy_i,
  output logic [W-1:0] y_o,
  output logic         is_minval_o
);

  localparam logic [W-1:0] MIN_CODE = W'(minval_code(W));
  localparam logic [W-1:0] MAX_CODE = W'(maxpos_code(W));
  localparam logic [W-1:0] NEG_MAX  = MIN_CODE | W'(1);

  logic [W-1:0] neg_x;
  logic         is_neg;
  logic         is_pos;

  assign neg_x       = ~x_i + W'(1);
  assign is_neg      = x_i[W-1];
  assign is_pos      = !x_i[W-1] && (x_i != '0);
  assign is_minval_o = (x_i == MIN_CODE);

  always_comb begin
    y_o = x_i;
    unique case (mode_i)
      PASS:    y_o = x_i;
      NEG:     y_o = neg_x;
      ABS:     y_o = is_neg ? neg_x : x_i;
      NEGABS:  y_o = is_pos ? neg_x : x_i;
      default: y_o = x_i;
    endcase
    // Pass mode forwards the minval code untouched regardless of policy.
    if (mode_i != PASS && is_minval_o) begin
      case (policy_i)
        ZERO:    y_o = '0;
        SAT:     y_o = (mode_i == NEGABS) ? NEG_MAX : MAX_CODE;
        default: y_o = MIN_CODE;
      endcase
    end
  end

endmodule

// File: rtl/mxint_block_negate_stream.sv
// Streaming MX block negate: LANES elements per beat, per-block mode/policy/scale
// latched on beat 0, single registered output stage. MXINT_NEG_STATS_EN adds o_minval_count.
module mxint_block_negate_stream
  import mxint_pkg::*;
#(
  parameter int ELEM_WIDTH  = 8,
  parameter int BLOCK_SIZE  = 32,
  parameter int LANES       = 8,
  parameter int SCALE_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_in_ready,
  input  logic [LANES*ELEM_WIDTH-1:0] i_elements,
  input  logic [SCALE_WIDTH-1:0]      i_scale,
  input  logic [1:0]                  i_mode,
  input  logic [1:0]                  i_minval_policy,
  output logic                        o_valid,
  input  logic                        i_out_ready,
  output logic [LANES*ELEM_WIDTH-1:0] o_elements,
  output logic [SCALE_WIDTH-1:0]      o_scale,
  output logic                        o_first,
  output logic                        o_last
`ifdef MXINT_NEG_STATS_EN
  ,
  output logic [$clog2(BLOCK_SIZE+1)-1:0] o_minval_count
`endif
);

  localparam int BEATS  = beats_per_block(BLOCK_SIZE, LANES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic                        accept;
  logic                        beat_is_first;
  logic                        beat_is_last;
  logic [BEAT_W-1:0]           beat_q;
  logic [BEAT_W-1:0]           beat_d;
  mode_e                       mode_q;
  mode_e                       eff_mode;
  policy_e                     policy_q;
  policy_e                     eff_policy;
  logic [SCALE_WIDTH-1:0]      scale_q;
  logic [SCALE_WIDTH-1:0]      eff_scale;
  logic [LANES*ELEM_WIDTH-1:0] lane_y;
  logic [LANES-1:0]            lane_minval;

  logic                        valid_q;
  logic [LANES*ELEM_WIDTH-1:0] elements_q;
  logic [SCALE_WIDTH-1:0]      out_scale_q;
  logic                        first_q;
  logic                        last_q;

  assign o_in_ready    = !valid_q || i_out_ready;
  assign accept        = i_valid && o_in_ready;
  assign beat_is_first = (beat_q == '0);
  assign beat_is_last  = (beat_q == LAST_BEAT);
  assign beat_d        = beat_is_last ? '0 : beat_q + BEAT_W'(1);

  // Beat 0 uses the live controls so it agrees with what gets latched.
  assign eff_mode   = beat_is_first ? mode_e'(i_mode) : mode_q;
  assign eff_policy = beat_is_first ? policy_e'(i_minval_policy) : policy_q;
  assign eff_scale  = beat_is_first ? i_scale : scale_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mxint_lane_negate #(
      .W(ELEM_WIDTH)
    ) u_lane (
      .x_i        (i_elements[gi*ELEM_WIDTH +: ELEM_WIDTH]),
      .mode_i     (eff_mode),
      .policy_i   (eff_policy),
      .y_o        (lane_y[gi*ELEM_WIDTH +: ELEM_WIDTH]),
      .is_minval_o(lane_minval[gi])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_q      <= '0;
      mode_q      <= PASS;
      policy_q    <= KEEP;
      scale_q     <= '0;
      valid_q     <= 1'b0;
      elements_q  <= '0;
      out_scale_q <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      if (accept) begin
        beat_q <= beat_d;
        if (beat_is_first) begin
          mode_q   <= eff_mode;
          policy_q <= eff_policy;
          scale_q  <= eff_scale;
        end
        valid_q     <= 1'b1;
        elements_q  <= lane_y;
        out_scale_q <= eff_scale;
        first_q     <= beat_is_first;
        last_q      <= beat_is_last;
      end else if (i_out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_elements = elements_q;
  assign o_scale    = out_scale_q;
  assign o_first    = first_q;
  assign o_last     = last_q;

`ifdef MXINT_NEG_STATS_EN
  localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lane_cnt;
  logic [CNT_W-1:0] block_total;
  logic [CNT_W-1:0] minval_count_q;

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_cnt = lane_cnt + CNT_W'(lane_minval[i]);
    end
  end

  // Beat 0 starts a fresh total instead of adding to the previous block.
  assign block_total = (beat_is_first ? '0 : cnt_q) + lane_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q          <= '0;
      minval_count_q <= '0;
    end else if (accept) begin
      cnt_q          <= block_total;
      minval_count_q <= beat_is_last ? block_total : '0;
    end
  end

  assign o_minval_count = minval_count_q;
`else
  logic unused_minval;
  assign unused_minval = ^lane_minval;
`endif

endmodule

// File: tb/tb_mxint_block_negate_stream.sv
// Directed self-checking bench for mxint_block_negate_stream (8-bit, 8 lanes, 4 beats).
// Stats checks are compiled in when MXINT_NEG_STATS_EN is defined.
module tb_mxint_block_negate_stream;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_in_ready;
  logic [63:0] i_elements;
  logic [7:0]  i_scale;
  logic [1:0]  i_mode;
  logic [1:0]  i_minval_policy;
  logic        o_valid;
  logic        i_out_ready;
  logic [63:0] o_elements;
  logic [7:0]  o_scale;
  logic        o_first;
  logic        o_last;
`ifdef MXINT_NEG_STATS_EN
  logic [5:0]  o_minval_count;
`endif

  int tests = 0;
  int fails = 0;

  mxint_block_negate_stream #(
    .ELEM_WIDTH (8),
    .BLOCK_SIZE (32),
    .LANES      (8),
    .SCALE_WIDTH(8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_in_ready     (o_in_ready),
    .i_elements     (i_elements),
    .i_scale        (i_scale),
    .i_mode         (i_mode),
    .i_minval_policy(i_minval_policy),
    .o_valid        (o_valid),
    .i_out_ready    (i_out_ready),
    .o_elements     (o_elements),
    .o_scale        (o_scale),
    .o_first        (o_first),
    .o_last         (o_last)
`ifdef MXINT_NEG_STATS_EN
    ,
    .o_minval_count (o_minval_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Sends one 4-beat block with downstream ready; beats 1-3 drive alternate controls
  // which must be ignored. Every output beat is checked.
  task automatic send_block(input string name, input logic [63:0] elem, input logic [63:0] exp,
                            input logic [7:0] scale, input logic [1:0] mode, input logic [1:0] pol,
                            input logic [7:0] alt_scale, input logic [1:0] alt_mode,
                            input logic [1:0] alt_pol);
    for (int b = 0; b < 4; b++) begin
      i_valid         = 1'b1;
      i_elements      = elem;
      i_scale         = (b == 0) ? scale : alt_scale;
      i_mode          = (b == 0) ? mode : alt_mode;
      i_minval_policy = (b == 0) ? pol : alt_pol;
      step();
      $display("[TB] %s beat %0d: out=%h scale=%h first=%0b last=%0b", name, b, o_elements,
               o_scale, o_first, o_last);
      chk({name, ".valid"}, 64'(o_valid), 64'd1);
      chk({name, ".elem"}, o_elements, exp);
      chk({name, ".scale"}, 64'(o_scale), 64'(scale));
      chk({name, ".first"}, 64'(o_first), 64'(b == 0));
      chk({name, ".last"}, 64'(o_last), 64'(b == 3));
    end
    i_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b1;
    i_elements = '0; i_scale = '0; i_mode = 2'b00; i_minval_policy = 2'b00;
    step();
    step();
    $display("[TB] reset: valid=%0b out=%h scale=%h", o_valid, o_elements, o_scale);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.elem", o_elements, 64'd0);
    chk("rst.scale", 64'(o_scale), 64'd0);
    chk("rst.first", 64'(o_first), 64'd0);
    chk("rst.last", 64'(o_last), 64'd0);
    chk("rst.in_ready", 64'(o_in_ready), 64'd1);
`ifdef MXINT_NEG_STATS_EN
    chk("rst.count", 64'(o_minval_count), 64'd0);
`endif
    i_rst = 1'b0;
    step();

    // Negate with keep, back to back.
    send_block("neg", 64'hF010_8005_FF00_7F01, 64'h10F0_80FB_0100_81FF,
               8'h11, 2'b01, 2'b00, 8'h11, 2'b01, 2'b00);
    step();
    chk("idle.valid", 64'(o_valid), 64'd0);

    // Minval policies.
    send_block("neg_zero", 64'h8080_8080_8080_8080, 64'h0000_0000_0000_0000,
               8'h01, 2'b01, 2'b01, 8'h01, 2'b01, 2'b01);
    send_block("neg_sat", 64'h8080_8080_8080_8080, 64'h7F7F_7F7F_7F7F_7F7F,
               8'h02, 2'b01, 2'b10, 8'h02, 2'b01, 2'b10);
    send_block("negabs_sat", 64'h8080_8080_8080_8080, 64'h8181_8181_8181_8181,
               8'h03, 2'b11, 2'b10, 8'h03, 2'b11, 2'b10);
    send_block("pass_sat", 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
               8'h04, 2'b00, 2'b10, 8'h04, 2'b00, 2'b10);
    send_block("abs_sat", 64'h8080_8080_8080_8080, 64'h7F7F_7F7F_7F7F_7F7F,
               8'h05, 2'b10, 2'b10, 8'h05, 2'b10, 2'b10);
    send_block("neg_pol11", 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
               8'h06, 2'b01, 2'b11, 8'h06, 2'b01, 2'b11);
    // Neg-abs on mixed signs: 0x05 -> 0xFB, 0xFB stays, 0x00 stays.
    send_block("negabs", 64'h0005_FB00_05FB_0005, 64'h00FB_FB00_FBFB_00FB,
               8'h07, 2'b11, 2'b00, 8'h07, 2'b11, 2'b00);

    // Latch: beats 1-3 drive negate/scale 0 but must stay abs/0x7E.
    send_block("latch", 64'h0AF6_0AF6_0AF6_0AF6, 64'h0A0A_0A0A_0A0A_0A0A,
               8'h7E, 2'b10, 2'b00, 8'h00, 2'b01, 2'b01);
    step();

    // Backpressure with pass mode so outputs equal inputs.
    i_out_ready = 1'b0;
    i_valid = 1'b1; i_mode = 2'b00; i_minval_policy = 2'b00; i_scale = 8'h22;
    i_elements = 64'h1111_1111_1111_1100;
    step();
    chk("bp.load.valid", 64'(o_valid), 64'd1);
    chk("bp.load.elem", o_elements, 64'h1111_1111_1111_1100);
    i_elements = 64'h2222_2222_2222_2201;
    for (int c = 0; c < 3; c++) begin
      step();
      $display("[TB] bp stall %0d: in_ready=%0b out=%h", c, o_in_ready, o_elements);
      chk("bp.stall.in_ready", 64'(o_in_ready), 64'd0);
      chk("bp.stall.valid", 64'(o_valid), 64'd1);
      chk("bp.stall.elem", o_elements, 64'h1111_1111_1111_1100);
      chk("bp.stall.first", 64'(o_first), 64'd1);
    end
    i_out_ready = 1'b1;
    step();
    $display("[TB] bp beat 1: out=%h", o_elements);
    chk("bp.b1.elem", o_elements, 64'h2222_2222_2222_2201);
    chk("bp.b1.first", 64'(o_first), 64'd0);
    i_elements = 64'h3333_3333_3333_3302;
    step();
    $display("[TB] bp beat 2: out=%h", o_elements);
    chk("bp.b2.elem", o_elements, 64'h3333_3333_3333_3302);
    i_elements = 64'h4444_4444_4444_4403;
    step();
    $display("[TB] bp beat 3: out=%h last=%0b", o_elements, o_last);
    chk("bp.b3.elem", o_elements, 64'h4444_4444_4444_4403);
    chk("bp.b3.last", 64'(o_last), 64'd1);
    chk("bp.b3.scale", 64'(o_scale), 64'h22);
    i_valid = 1'b0;
    step();
    chk("bp.drain.valid", 64'(o_valid), 64'd0);

    // Reset after two accepted beats.
    i_valid = 1'b1; i_mode = 2'b01; i_minval_policy = 2'b00; i_scale = 8'h33;
    i_elements = 64'h0101_0101_0101_0101;
    step();
    step();
    i_valid = 1'b0; i_rst = 1'b1;
    step();
    $display("[TB] mid-block reset: valid=%0b out=%h", o_valid, o_elements);
    chk("mrst.valid", 64'(o_valid), 64'd0);
    chk("mrst.elem", o_elements, 64'd0);
    chk("mrst.scale", 64'(o_scale), 64'd0);
    chk("mrst.first", 64'(o_first), 64'd0);
    i_rst = 1'b0;
    step();
    i_valid = 1'b1; i_mode = 2'b10; i_scale = 8'h44;
    i_elements = 64'hF6F6_F6F6_F6F6_F6F6;
    step();
    $display("[TB] post-reset beat: out=%h first=%0b", o_elements, o_first);
    chk("prst.first", 64'(o_first), 64'd1);
    chk("prst.last", 64'(o_last), 64'd0);
    chk("prst.elem", o_elements, 64'h0A0A_0A0A_0A0A_0A0A);
    chk("prst.scale", 64'(o_scale), 64'h44);
    i_mode = 2'b01;
    step();
    step();
    step();
    chk("prst.b3.last", 64'(o_last), 64'd1);
    chk("prst.b3.elem", o_elements, 64'h0A0A_0A0A_0A0A_0A0A);
    i_valid = 1'b0;
    step();

`ifdef MXINT_NEG_STATS_EN
    // Five minval codes in a pass-mode block: two on beat 0, three on beat 2.
    i_valid = 1'b1; i_mode = 2'b00; i_minval_policy = 2'b00; i_scale = 8'h55;
    for (int b = 0; b < 4; b++) begin
      case (b)
        0:       i_elements = 64'h0000_0080_0000_8000;
        2:       i_elements = 64'h8000_8000_0080_0000;
        default: i_elements = 64'h0102_0304_0506_0708;
      endcase
      step();
      $display("[TB] stats beat %0d: count=%0d last=%0b", b, o_minval_count, o_last);
      chk("stats.count", 64'(o_minval_count), (b == 3) ? 64'd5 : 64'd0);
    end
    i_valid = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
